// File: rtl/synth_pkg.sv
// Shared constants and scan-FSM encoding for the ADC channel scanner and its parameter-mapping stage.
package synth_pkg;

  localparam int unsigned MAX_CH = 8;
  localparam int unsigned ADDR_W = 3;

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_UPDATE  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/knob_hyst_cmp.sv
// Combinational |a - b| at W+1 bits (no wrap) compared against the hysteresis threshold.
module knob_hyst_cmp #(
  parameter int unsigned W    = 8,
  parameter int unsigned HYST = 2
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_ge
);

  logic [W:0] w_diff;

  always_comb begin
    if (i_a >= i_b) w_diff = {1'b0, i_a} - {1'b0, i_b};
    else            w_diff = {1'b0, i_b} - {1'b0, i_a};
  end

  assign o_ge = 32'(w_diff) >= HYST;

endmodule

// File: rtl/knob_scanner.sv
// Round-robin ADC channel scanner: discards the pipelined result, captures the next one,
// and stores it per channel only when it moved by at least HYST.
module knob_scanner
  import synth_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned W      = 8,
  parameter int unsigned HYST   = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] adc_addr,
  input  logic [W-1:0]      adc_q,
  input  logic              adc_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [W-1:0]      rd_data,
  output logic [NUM_CH-1:0] changed,
  input  logic [NUM_CH-1:0] clr_changed,
  output logic              scan_done
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  scan_state_t       r_state, w_next_state;
  logic [CH_W-1:0]   r_ch, w_next_ch;
  logic [W-1:0]      r_sample;
  logic [W-1:0]      r_stored [NUM_CH];
  logic [NUM_CH-1:0] r_valid, r_changed, w_set;
  logic [W-1:0]      r_rd_data;
  logic              r_scan_done;
  logic [ADDR_W-1:0] r_adc_addr;
  logic              w_capture, w_update, w_ge, w_write;
  logic [W-1:0]      w_rd_mux [MAX_CH];

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_update     = 1'b0;
    unique case (r_state)
      ST_SETTLE:  if (adc_valid) w_next_state = ST_CAPTURE;
      ST_CAPTURE: if (adc_valid) begin
        w_capture    = 1'b1;
        w_next_state = ST_UPDATE;
      end
      ST_UPDATE: begin
        w_update     = 1'b1;
        w_next_state = ST_SETTLE;
      end
      default:    w_next_state = ST_SETTLE;
    endcase
  end

  knob_hyst_cmp #(
    .W    (W),
    .HYST (HYST)
  ) u_cmp (
    .i_a  (r_sample),
    .i_b  (r_stored[r_ch]),
    .o_ge (w_ge)
  );

  // First capture of a channel always lands, regardless of the threshold.
  assign w_write   = w_update && (!r_valid[r_ch] || w_ge);
  assign w_next_ch = r_ch + 1'b1;

  always_comb begin
    w_set       = '0;
    w_set[r_ch] = w_write;
  end

  // Unused address slots read as zero, so any rd_addr >= NUM_CH returns 0.
  for (genvar g = 0; g < MAX_CH; g++) begin : g_rd
    if (g < NUM_CH) begin : g_live
      assign w_rd_mux[g] = r_stored[g];
    end else begin : g_pad
      assign w_rd_mux[g] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_SETTLE;
      r_ch        <= '0;
      r_adc_addr  <= '0;
      r_sample    <= '0;
      r_valid     <= '0;
      r_changed   <= '0;
      r_scan_done <= 1'b0;
      r_rd_data   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) r_stored[i] <= '0;
    end else begin
      r_state     <= w_next_state;
      r_scan_done <= w_update && (r_ch == CH_W'(NUM_CH - 1));
      r_changed   <= (r_changed & ~clr_changed) | w_set;
      r_rd_data   <= w_rd_mux[rd_addr];
      if (w_capture) r_sample <= adc_q;
      if (w_update) begin
        r_valid[r_ch] <= 1'b1;
        r_ch          <= w_next_ch;
        r_adc_addr    <= ADDR_W'(w_next_ch);
      end
      if (w_write) r_stored[r_ch] <= r_sample;
    end
  end

  assign adc_addr  = r_adc_addr;
  assign rd_data   = r_rd_data;
  assign changed   = r_changed;
  assign scan_done = r_scan_done;

endmodule

// File: tb/tb_knob_scanner.sv
// Randomized bench for knob_scanner against a per-channel behavioural model of the scan.
module tb_knob_scanner;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned W      = 8;
  localparam int unsigned HYST   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [2:0]        adc_addr;
  logic [W-1:0]      adc_q = '0;
  logic              adc_valid = 1'b0;
  logic [2:0]        rd_addr = '0;
  logic [W-1:0]      rd_data;
  logic [NUM_CH-1:0] changed;
  logic [NUM_CH-1:0] clr_changed = '0;
  logic              scan_done;

  int n_checks = 0;
  int n_fail   = 0;
  int sd_seen  = 0;
  int sd_expected = 0;

  logic [W-1:0]      m_stored [NUM_CH];
  bit                m_valid  [NUM_CH];
  logic [NUM_CH-1:0] m_changed;
  int                m_ch;
  int                m_phase;

  knob_scanner #(
    .NUM_CH (NUM_CH),
    .W      (W),
    .HYST   (HYST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .adc_addr    (adc_addr),
    .adc_q       (adc_q),
    .adc_valid   (adc_valid),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .changed     (changed),
    .clr_changed (clr_changed),
    .scan_done   (scan_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (scan_done === 1'b1) sd_seen++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_stored[i] = '0;
      m_valid[i]  = 0;
    end
    m_changed = '0;
    m_ch      = 0;
    m_phase   = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; adc_valid = 1'b0; clr_changed = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    sd_seen = 0; sd_expected = 0;
  endtask

  // One adc_valid pulse; clr is held during the cycle in which an UPDATE would follow.
  task automatic pulse(input logic [W-1:0] v, input logic [NUM_CH-1:0] clr);
    logic [W-1:0] old;
    bit           exp_sd;
    int           ch;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (adc_addr !== 3'(m_ch)) begin
      n_fail++;
      $display("FAIL adc_addr: got %0d expected %0d", adc_addr, m_ch);
    end
    adc_q = v; adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0; adc_q = W'($urandom); clr_changed = clr; rd_addr = 3'(m_ch);
    @(negedge clk);
    clr_changed = '0;
    ch  = m_ch;
    old = m_stored[ch];
    m_changed &= ~clr;
    exp_sd = 0;
    if (m_phase == 0) m_phase = 1;
    else begin
      m_phase = 0;
      if (!m_valid[ch] || absdiff(int'(v), int'(old)) >= int'(HYST)) begin
        m_stored[ch]  = v;
        m_changed[ch] = 1'b1;
      end
      m_valid[ch] = 1;
      exp_sd = (ch == NUM_CH - 1);
      if (exp_sd) sd_expected++;
      m_ch = (m_ch + 1) % NUM_CH;
    end
    n_checks++;
    if (rd_data !== old) begin
      n_fail++;
      $display("FAIL read_during_write ch%0d: got %h expected %h", ch, rd_data, old);
    end
    n_checks++;
    if (scan_done !== exp_sd) begin
      n_fail++;
      $display("FAIL scan_done ch%0d: got %b expected %b", ch, scan_done, exp_sd);
    end
    n_checks++;
    if (changed !== m_changed) begin
      n_fail++;
      $display("FAIL changed: got %h expected %h", changed, m_changed);
    end
  endtask

  task automatic scan_to(input int target, input logic [W-1:0] v, input logic [NUM_CH-1:0] clr);
    while (m_ch != target) begin
      pulse(W'($urandom), '0);
      pulse(m_stored[m_ch], '0);
    end
    pulse(W'($urandom), '0);
    pulse(v, clr);
  endtask

  task automatic read_ch(input int a, output logic [W-1:0] d);
    @(negedge clk);
    rd_addr = 3'(a);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic check_reads();
    logic [W-1:0] d;
    for (int a = 0; a < NUM_CH; a++) begin
      read_ch(a, d);
      n_checks++;
      if (d !== m_stored[a]) begin
        n_fail++;
        $display("FAIL rd_data ch%0d: got %h expected %h", a, d, m_stored[a]);
      end
    end
  endtask

  task automatic clear_all();
    @(negedge clk);
    clr_changed = '1;
    @(negedge clk);
    clr_changed = '0;
    m_changed = '0;
    n_checks++;
    if (changed !== '0) begin
      n_fail++;
      $display("FAIL clear_changed: got %h expected 00", changed);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (adc_addr !== 3'd0 || scan_done !== 1'b0 || changed !== '0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: addr=%0d sd=%b chg=%h rd=%h expected 0/0/00/00",
               adc_addr, scan_done, changed, rd_data);
    end
    reset = 1'b0;
    model_reset();
    sd_seen = 0; sd_expected = 0;
    check_reads();
  endtask

  task automatic test_first_scan();
    logic [W-1:0] d;
    do_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      pulse(W'($urandom), '0);
      pulse(W'(8'h40 + c), '0);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      read_ch(c, d);
      n_checks++;
      if (d !== W'(8'h40 + c)) begin
        n_fail++;
        $display("FAIL first_scan ch%0d: got %h expected %h", c, d, 8'h40 + c);
      end
    end
    n_checks++;
    if (changed !== 8'hFF) begin
      n_fail++;
      $display("FAIL first_scan changed: got %h expected ff", changed);
    end
    @(negedge clk); #1;
    n_checks++;
    if (sd_seen !== 1) begin
      n_fail++;
      $display("FAIL first_scan scan_done count: got %0d expected 1", sd_seen);
    end
  endtask

  task automatic test_hysteresis();
    logic [W-1:0] d;
    scan_to(3, 8'h80, '0);
    clear_all();
    scan_to(3, 8'h81, '0);
    read_ch(3, d);
    n_checks++;
    if (d !== 8'h80 || changed[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL hyst_small: got %h/%b expected 80/0", d, changed[3]);
    end
    scan_to(3, 8'h82, '0);
    read_ch(3, d);
    n_checks++;
    if (d !== 8'h82 || changed[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL hyst_step: got %h/%b expected 82/1", d, changed[3]);
    end
  endtask

  task automatic test_boundary();
    logic [W-1:0] d;
    logic [W-1:0] seq [4];
    logic [W-1:0] want [4];
    seq  = '{8'h00, 8'hFF, 8'hFE, 8'h00};
    want = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    for (int k = 0; k < 4; k++) begin
      scan_to(2, seq[k], '0);
      read_ch(2, d);
      n_checks++;
      if (d !== want[k]) begin
        n_fail++;
        $display("FAIL boundary step%0d: got %h expected %h", k, d, want[k]);
      end
    end
  endtask

  task automatic test_clr_race();
    logic [W-1:0] v;
    clear_all();
    while (m_ch != 5) begin
      pulse(W'($urandom), '0);
      pulse(m_stored[m_ch], '0);
    end
    v = m_stored[5] ^ 8'h10;
    pulse(W'($urandom), '0);
    pulse(v, 8'h20);
    n_checks++;
    if (changed[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_vs_set: got %b expected 1", changed[5]);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d;
    while (m_ch != 6) begin
      pulse(W'($urandom), '0);
      pulse(m_stored[m_ch], '0);
    end
    pulse(W'($urandom), '0);
    do_reset();
    n_checks++;
    if (adc_addr !== 3'd0 || changed !== '0) begin
      n_fail++;
      $display("FAIL reset_in_capture: addr=%0d chg=%h expected 0/00", adc_addr, changed);
    end
    check_reads();
    pulse(W'($urandom), '0);
    pulse(8'h5A, '0);
    read_ch(0, d);
    n_checks++;
    if (d !== 8'h5A || changed !== 8'h01) begin
      n_fail++;
      $display("FAIL post_reset_capture: got %h/%h expected 5a/01", d, changed);
    end
    pulse(W'($urandom), '0);
    @(negedge clk);
    adc_q = 8'hC3; adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    sd_seen = 0; sd_expected = 0;
    read_ch(1, d);
    n_checks++;
    if (d !== 8'h00 || changed !== '0) begin
      n_fail++;
      $display("FAIL reset_in_update: got %h/%h expected 00/00", d, changed);
    end
  endtask

  task automatic test_scan_sequence();
    logic [W-1:0] v;
    for (int n = 0; n < 8 * 2 * NUM_CH; n++) begin
      if (m_phase == 0 || $urandom_range(0, 3) == 0) v = W'($urandom);
      else v = W'(int'(m_stored[m_ch]) + int'($urandom_range(0, 6)) - 3);
      pulse(v, (($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0));
    end
    check_reads();
    @(negedge clk); #1;
    n_checks++;
    if (sd_seen !== sd_expected) begin
      n_fail++;
      $display("FAIL scan_done total: got %0d expected %0d", sd_seen, sd_expected);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_scan();
    test_hysteresis();
    test_boundary();
    test_clr_race();
    test_reset_mid();
    test_scan_sequence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
